wb_unit: RTL
============

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of result data and WD3.
REQ-002 Parameter: ADDRESS_BIT_WIDTH, 5, register index width.
REQ-003 Parameter: NB_OF_REGS, 32, number of architectural registers tracked by the scoreboard.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  block enable; low freezes all state.
REQ-007 alu_valid / alu_ready  in/out  1/1  ALU result handshake.
REQ-008 alu_rd / alu_data  in  ADDRESS_BIT_WIDTH/DATA_WIDTH  ALU destination index and result.
REQ-009 lsu_valid / lsu_ready  in/out  1/1  load-result handshake.
REQ-010 lsu_rd / lsu_data  in  ADDRESS_BIT_WIDTH/DATA_WIDTH  load destination index and data.
REQ-011 issue_valid / issue_rd  in  1/ADDRESS_BIT_WIDTH  marks issue_rd pending (scoreboard set).
REQ-012 rs1_addr / rs2_addr  in  ADDRESS_BIT_WIDTH  scoreboard query indices.
REQ-013 rs1_busy / rs2_busy  out  1  queried register has a pending write.
REQ-014 A3 / WD3 / WE3  out  ADDRESS_BIT_WIDTH/DATA_WIDTH/1  register-file write port, registered.

Function
REQ-015 A source transfer SHALL occur when valid and ready are both high at a rising edge with en=1 and rst=0.
REQ-016 lsu_ready SHALL equal en and not rst; LSU is never back-pressured.
REQ-017 alu_ready SHALL equal en and not rst and hold buffer empty.
REQ-018 Per-cycle write selection priority SHALL be: LSU transfer, else hold buffer, else ALU transfer.
REQ-019 ALU transfer coinciding with LSU transfer SHALL be captured in the one-entry hold buffer.
REQ-020 Hold buffer SHALL drain in the first enabled cycle without lsu_valid; ALU results SHALL commit in acceptance order.
REQ-021 Selected entry SHALL appear on A3/WD3 with WE3=1 exactly one cycle after its transfer or drain (latency 1).
REQ-022 Entries with rd=0 SHALL be consumed normally but SHALL drive WE3=0 and not affect the scoreboard.
REQ-023 WE3 SHALL be 0 in any cycle with no selected entry; A3/WD3 SHALL hold previous values then.
REQ-024 Scoreboard: issue_valid with issue_rd!=0 SHALL set busy[issue_rd] at the edge.
REQ-025 A registered output cycle with WE3=1 SHALL clear busy[A3] at the following edge.
REQ-026 Simultaneous set and clear of the same index SHALL leave the bit set.
REQ-027 busy[0] SHALL read 0 always; rs1_busy/rs2_busy SHALL be combinational lookups of busy.
REQ-028 en=0 SHALL hold hold buffer and busy bits, drive both readies low, and force WE3=0 at the next edge.

Reset
REQ-029 rst=1 at an edge SHALL give WE3=0, A3=0, WD3=0, hold buffer empty, all busy bits 0.
REQ-030 During rst=1 alu_ready=0 and lsu_ready=0; an entry in flight or held at reset SHALL be discarded.

Configuration
REQ-031 Macro WB_BYPASS_EN: when defined, outputs rs1_fwd_valid/rs1_fwd_data and rs2_fwd_valid/rs2_fwd_data (1/DATA_WIDTH) SHALL exist.
REQ-032 fwd_valid SHALL be 1 when WE3=1 and A3 equals rsN_addr (nonzero), with fwd_data=WD3; rsN_busy SHALL then read 0.
REQ-033 Without WB_BYPASS_EN these ports SHALL be absent and busy SHALL clear only per REQ-025.

Verification
REQ-034 ALU-only: alu rd=5 data=0x1234 -> next cycle WE3=1, A3=5, WD3=0x1234.
REQ-035 Collision: same-cycle lsu rd=3 0xAAAA and alu rd=4 0xBBBB -> cycle+1 writes x3, cycle+2 writes x4; alu_ready=0 in cycle+1.
REQ-036 Scoreboard: issue rd=7, query rs1=7 -> rs1_busy=1 until the x7 write cycle, 0 after; same-cycle reissue of 7 keeps it 1.
REQ-037 x0: alu rd=0 data=0xFFFF -> WE3 stays 0, busy unchanged, alu_ready stays 1.
REQ-038 Reset mid-operation: held ALU entry plus busy x9, assert rst -> no write of held entry, busy all 0, WE3=0.
REQ-039 With WB_BYPASS_EN: alu rd=6 0x55, rs2_addr=6 -> during write cycle rs2_fwd_valid=1, rs2_fwd_data=0x55.

Source files
------------

// File: rtl/wb_unit.sv
// Write-back arbiter: LSU first, then a one-entry ALU hold buffer, then a fresh ALU result,
// with a pending-write scoreboard. Define WB_BYPASS_EN to add per-source forwarding outputs.
module wb_unit #(
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned ADDRESS_BIT_WIDTH = 5,
   parameter int unsigned NB_OF_REGS        = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [ADDRESS_BIT_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]        alu_data,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [ADDRESS_BIT_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0]        lsu_data,
   input  logic                         issue_valid,
   input  logic [ADDRESS_BIT_WIDTH-1:0] issue_rd,
   input  logic [ADDRESS_BIT_WIDTH-1:0] rs1_addr,
   input  logic [ADDRESS_BIT_WIDTH-1:0] rs2_addr,
   output logic                         rs1_busy,
   output logic                         rs2_busy,
`ifdef WB_BYPASS_EN
   output logic                         rs1_fwd_valid,
   output logic [DATA_WIDTH-1:0]        rs1_fwd_data,
   output logic                         rs2_fwd_valid,
   output logic [DATA_WIDTH-1:0]        rs2_fwd_data,
`endif
   output logic [ADDRESS_BIT_WIDTH-1:0] A3,
   output logic [DATA_WIDTH-1:0]        WD3,
   output logic                         WE3
);

   logic                         hold_valid_q, hold_valid_d;
   logic [ADDRESS_BIT_WIDTH-1:0] hold_rd_q, hold_rd_d;
   logic [DATA_WIDTH-1:0]        hold_data_q, hold_data_d;
   logic                         we3_q, we3_d;
   logic [ADDRESS_BIT_WIDTH-1:0] a3_q, a3_d;
   logic [DATA_WIDTH-1:0]        wd3_q, wd3_d;
   logic [NB_OF_REGS-1:0]        busy_q, busy_d;

   logic                         active;
   logic                         lsu_xfer;
   logic                         alu_xfer;
   logic                         sel_valid;
   logic [ADDRESS_BIT_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0]        sel_data;
   logic                         rs1_hit;
   logic                         rs2_hit;

   assign active    = en & ~rst;
   assign lsu_ready = active;
   assign alu_ready = active & ~hold_valid_q;
   assign lsu_xfer  = lsu_valid & lsu_ready;
   assign alu_xfer  = alu_valid & alu_ready;

   // An ALU result only lands in the hold buffer when it collides with an LSU transfer.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_rd_d    = hold_rd_q;
      hold_data_d  = hold_data_q;
      sel_valid    = 1'b0;
      sel_rd       = lsu_rd;
      sel_data     = lsu_data;
      if (lsu_xfer) begin
         sel_valid = 1'b1;
         if (alu_xfer) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = alu_rd;
            hold_data_d  = alu_data;
         end
      end else if (active && hold_valid_q) begin
         sel_valid    = 1'b1;
         sel_rd       = hold_rd_q;
         sel_data     = hold_data_q;
         hold_valid_d = 1'b0;
      end else if (alu_xfer) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end
   end

   // x0 entries are consumed but never reach the register file.
   always_comb begin
      we3_d = 1'b0;
      a3_d  = a3_q;
      wd3_d = wd3_q;
      if (sel_valid && (sel_rd != '0)) begin
         we3_d = 1'b1;
         a3_d  = sel_rd;
         wd3_d = sel_data;
      end
   end

   // Clear from the write now on the port, then set from issue so a same-index set wins.
   always_comb begin
      busy_d = busy_q;
      if (active) begin
         for (int i = 1; i < int'(NB_OF_REGS); i++) begin
            if (we3_q && (a3_q == ADDRESS_BIT_WIDTH'(i))) busy_d[i] = 1'b0;
            if (issue_valid && (issue_rd == ADDRESS_BIT_WIDTH'(i))) busy_d[i] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid_q <= 1'b0;
         hold_rd_q    <= '0;
         hold_data_q  <= '0;
         we3_q        <= 1'b0;
         a3_q         <= '0;
         wd3_q        <= '0;
         busy_q       <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_rd_q    <= hold_rd_d;
         hold_data_q  <= hold_data_d;
         we3_q        <= we3_d;
         a3_q         <= a3_d;
         wd3_q        <= wd3_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      for (int i = 0; i < int'(NB_OF_REGS); i++) begin
         if (rs1_addr == ADDRESS_BIT_WIDTH'(i)) rs1_hit = busy_q[i];
         if (rs2_addr == ADDRESS_BIT_WIDTH'(i)) rs2_hit = busy_q[i];
      end
   end

`ifdef WB_BYPASS_EN
   // we3_q already implies a nonzero A3, so a match can never be on x0.
   assign rs1_fwd_valid = we3_q && (a3_q == rs1_addr);
   assign rs2_fwd_valid = we3_q && (a3_q == rs2_addr);
   assign rs1_fwd_data  = wd3_q;
   assign rs2_fwd_data  = wd3_q;
   assign rs1_busy      = rs1_hit & ~rs1_fwd_valid;
   assign rs2_busy      = rs2_hit & ~rs2_fwd_valid;
`else
   assign rs1_busy = rs1_hit;
   assign rs2_busy = rs2_hit;
`endif

   assign A3  = a3_q;
   assign WD3 = wd3_q;
   assign WE3 = we3_q;

endmodule
